seq_shifter: RTL and testbench

//   Parametrised multi-cycle shift/rotate unit; successor to the 16-bit single-bit datapath shifter.

---
 rtl/shifter_pkg.sv | 48 ++++
 rtl/seq_shifter_step.sv | 52 +++++
 rtl/seq_shifter.sv | 126 ++++++++++++
 tb/tb_seq_shifter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_pkg
//  Description : Op codes, FSM state encoding and carry selection helper
//                shared by the sequential shift/rotate unit.
//  Revision    : 1.0  initial release
// ============================================================================
package shifter_pkg;

    localparam logic [2:0] SH_NONE = 3'b000;
    localparam logic [2:0] SH_LSL  = 3'b001;
    localparam logic [2:0] SH_LSR  = 3'b010;
    localparam logic [2:0] SH_ASR  = 3'b011;
    localparam logic [2:0] SH_ROL  = 3'b100;
    localparam logic [2:0] SH_ROR  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // True for codes that actually move bits; NONE and the reserved 11x codes pass through.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == SH_LSL) || (op == SH_LSR) || (op == SH_ASR) ||
               (op == SH_ROL) || (op == SH_ROR);
    endfunction

    // Picks the bit reported as carry for one step. Rotates report the bit that
    // wrapped, which lands at the opposite end of the result.
    function automatic logic carry_sel(input logic [2:0] op,
                                       input logic       lsl_out,
                                       input logic       lsr_out,
                                       input logic       res_lsb,
                                       input logic       res_msb);
        logic c;
        case (op)
            SH_LSL:         c = lsl_out;
            SH_LSR, SH_ASR: c = lsr_out;
            SH_ROL:         c = res_lsb;
            SH_ROR:         c = res_msb;
            default:        c = 1'b0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_shifter_step.sv
`default_nettype none
// ============================================================================
//  Module      : shift_step
//  Description : Combinational single-step shifter. Shifts or rotates the
//                operand by k (0..STEP) and reports the last bit moved out.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_step
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int STEP  = 1,
    localparam int KW    = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       op,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] data_shifted,
    output logic             carry_bit
);

    // One extra bit on each side catches the last bit pushed out of the word.
    logic [WIDTH:0]   w_lsl_ext;
    logic [WIDTH:0]   w_lsr_ext;
    logic [WIDTH-1:0] w_asr;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;

    assign w_lsl_ext = {1'b0, data} << k;
    assign w_lsr_ext = {data, 1'b0} >> k;
    assign w_asr     = WIDTH'($signed(data) >>> k);
    assign w_rol     = (data << k) | (data >> (WIDTH - int'(k)));
    assign w_ror     = (data >> k) | (data << (WIDTH - int'(k)));

    // Select the shifted word for the requested operation.
    always_comb begin
        data_shifted = data;
        case (op)
            SH_LSL:  data_shifted = w_lsl_ext[WIDTH-1:0];
            SH_LSR:  data_shifted = w_lsr_ext[WIDTH:1];
            SH_ASR:  data_shifted = w_asr;
            SH_ROL:  data_shifted = w_rol;
            SH_ROR:  data_shifted = w_ror;
            default: data_shifted = data;
        endcase
    end

    assign carry_bit = carry_sel(op, w_lsl_ext[WIDTH], w_lsr_ext[0],
                                 data_shifted[0], data_shifted[WIDTH-1]);

endmodule
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shifter
//  Description : Multi-cycle shift/rotate unit with valid/ready handshakes.
//                Moves up to STEP bits per cycle until the requested amount
//                is consumed, then holds the result until it is taken.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       shift_op,
    input  logic [AMT_W-1:0] amount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             carry_out,
    output logic             busy
);

    localparam int KW = $clog2(STEP) + 1;
    localparam logic [AMT_W:0] c_step_ext = (AMT_W + 1)'(STEP);
    localparam logic [KW-1:0]  c_step_k   = KW'(STEP);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_op;
    logic [AMT_W-1:0] r_remaining;
    logic             r_carry;

    logic             w_accept;
    logic             w_start_shift;
    logic [AMT_W:0]   w_rem_ext;
    logic [KW-1:0]    w_k;
    logic             w_last;
    logic [WIDTH-1:0] w_shifted;
    logic             w_step_carry;

    assign in_ready      = (r_state == ST_IDLE) & ~reset;
    assign w_accept      = in_valid & in_ready;
    assign w_start_shift = is_shift_op(shift_op) && (amount != '0);

    // Remaining is widened by one bit so STEP == WIDTH still compares correctly.
    assign w_rem_ext = {1'b0, r_remaining};
    assign w_k       = (w_rem_ext < c_step_ext) ? w_rem_ext[KW-1:0] : c_step_k;
    assign w_last    = (w_rem_ext <= c_step_ext);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data         (r_data),
        .op           (r_op),
        .k            (w_k),
        .data_shifted (w_shifted),
        .carry_bit    (w_step_carry)
    );

    // State register; reset abandons any request in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: trivial requests skip SHIFT; DONE waits for the consumer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_start_shift ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Operand/carry/remaining registers: load on accept, step while shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data      <= '0;
            r_op        <= SH_NONE;
            r_remaining <= '0;
            r_carry     <= 1'b0;
        end else if (w_accept) begin
            r_data      <= in_data;
            r_op        <= shift_op;
            r_remaining <= amount;
            r_carry     <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            r_data      <= w_shifted;
            r_carry     <= w_step_carry;
            r_remaining <= r_remaining - AMT_W'(w_k);
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_data  = r_data;
    assign carry_out = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_shifter
//  Description : Directed self-checking bench for seq_shifter, using one
//                STEP=1 and one STEP=4 instance at WIDTH=16.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_shifter;
    import shifter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = '0;
    logic [2:0]  shift_op = '0;
    logic [3:0]  amount = '0;
    logic        out_ready = 1'b0;

    logic        iv_a = 1'b0, iv_b = 1'b0;
    logic        ir_a, ov_a, co_a, busy_a;
    logic        ir_b, ov_b, co_b, busy_b;
    logic [15:0] od_a, od_b;

    logic        sel = 1'b0;
    logic        s_ready, s_valid, s_carry, s_busy;
    logic [15:0] s_data;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(16), .STEP(1)) u_step1 (
        .clk(clk), .reset(reset), .in_valid(iv_a), .in_ready(ir_a),
        .in_data(in_data), .shift_op(shift_op), .amount(amount),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .carry_out(co_a), .busy(busy_a)
    );

    seq_shifter #(.WIDTH(16), .STEP(4)) u_step4 (
        .clk(clk), .reset(reset), .in_valid(iv_b), .in_ready(ir_b),
        .in_data(in_data), .shift_op(shift_op), .amount(amount),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
        .carry_out(co_b), .busy(busy_b)
    );

    // Observe whichever instance the current step targets.
    always_comb begin
        s_ready = sel ? ir_b   : ir_a;
        s_valid = sel ? ov_b   : ov_a;
        s_carry = sel ? co_b   : co_a;
        s_busy  = sel ? busy_b : busy_a;
        s_data  = sel ? od_b   : od_a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request: latency is counted in edges after the accept edge, so a
    // trivial request (NONE, reserved, amount 0) completes at the accept edge.
    task automatic run(input logic which, input logic [15:0] d, input logic [2:0] op,
                       input logic [3:0] amt, input logic [15:0] ed, input logic ec,
                       input int elat, input bit poke, input int hold, input string tag);
        int lat;
        sel = which;
        @(negedge clk);
        check({tag, ":ready_before"}, 32'(s_ready), 32'd1);
        in_data = d; shift_op = op; amount = amt;
        if (which) iv_b = 1'b1; else iv_a = 1'b1;
        @(posedge clk); #1;
        iv_a = 1'b0; iv_b = 1'b0;
        lat = 0;
        while (s_valid !== 1'b1 && lat < 40) begin
            check({tag, ":busy_shift"},  32'(s_busy),  32'd1);
            check({tag, ":ready_shift"}, 32'(s_ready), 32'd0);
            if (poke) begin
                in_data = 16'h5A5A; shift_op = SH_LSL; amount = 4'd1;
                if (which) iv_b = 1'b1; else iv_a = 1'b1;
            end
            @(posedge clk); #1;
            lat++;
        end
        iv_a = 1'b0; iv_b = 1'b0;
        check({tag, ":latency"}, 32'(lat),     32'(elat));
        check({tag, ":valid"},   32'(s_valid), 32'd1);
        check({tag, ":data"},    32'(s_data),  32'(ed));
        check({tag, ":carry"},   32'(s_carry), 32'(ec));
        repeat (hold) begin
            @(posedge clk); #1;
            check({tag, ":hold_valid"}, 32'(s_valid), 32'd1);
            check({tag, ":hold_data"},  32'(s_data),  32'(ed));
            check({tag, ":hold_carry"}, 32'(s_carry), 32'(ec));
            check({tag, ":hold_ready"}, 32'(s_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ":valid_drop"}, 32'(s_valid), 32'd0);
        check({tag, ":ready_after"}, 32'(s_ready), 32'd1);
        check({tag, ":busy_after"}, 32'(s_busy), 32'd0);
        check({tag, ":data_kept"},  32'(s_data), 32'(ed));
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_valid", 32'(ov_a), 32'd0);
        check("rst_data",  32'(od_a), 32'd0);
        check("rst_carry", 32'(co_a), 32'd0);
        check("rst_busy",  32'(busy_a), 32'd0);
        check("rst_ready", 32'(ir_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_ready", 32'(ir_a), 32'd1);

        // Single-bit shifts of F0CF, STEP=1
        run(1'b0, 16'hF0CF, SH_LSL,  4'd1, 16'hE19E, 1'b1, 1, 1'b0, 0, "lsl1");
        run(1'b0, 16'hF0CF, SH_LSR,  4'd1, 16'h7867, 1'b1, 1, 1'b0, 0, "lsr1");
        run(1'b0, 16'hF0CF, SH_ASR,  4'd1, 16'hF867, 1'b1, 1, 1'b0, 0, "asr1");
        run(1'b0, 16'hF0CF, SH_NONE, 4'd1, 16'hF0CF, 1'b0, 0, 1'b0, 0, "none");
        run(1'b0, 16'hF0CF, 3'b111,  4'd5, 16'hF0CF, 1'b0, 0, 1'b0, 0, "reserved");

        // Full-distance ASR with ignored requests during SHIFT
        run(1'b0, 16'h8001, SH_ASR, 4'd15, 16'hFFFF, 1'b0, 15, 1'b1, 0, "asr15");

        // Rotates, STEP=1
        run(1'b0, 16'h0001, SH_ROR, 4'd1, 16'h8000, 1'b1, 1, 1'b0, 0, "ror1");
        run(1'b0, 16'h8001, SH_ROL, 4'd4, 16'h0018, 1'b0, 4, 1'b0, 0, "rol4");

        // STEP=4 instance, including a final partial step
        run(1'b1, 16'h1234, SH_LSL, 4'd9,  16'h6800, 1'b0, 3, 1'b0, 0, "s4_lsl9");
        run(1'b1, 16'hFFFF, SH_LSR, 4'd0,  16'hFFFF, 1'b0, 0, 1'b0, 0, "s4_lsr0");
        run(1'b1, 16'h0001, SH_ROR, 4'd15, 16'h0002, 1'b0, 4, 1'b1, 0, "s4_ror15");
        run(1'b1, 16'h8001, SH_ASR, 4'd15, 16'hFFFF, 1'b0, 4, 1'b0, 0, "s4_asr15");

        // Backpressure: result held for 5 cycles
        run(1'b0, 16'hF0CF, SH_LSR, 4'd1, 16'h7867, 1'b1, 1, 1'b0, 5, "bp");

        // Reset in the middle of a long shift
        sel = 1'b0;
        @(negedge clk);
        in_data = 16'h8001; shift_op = SH_ASR; amount = 4'd15; iv_a = 1'b1;
        @(posedge clk); #1;
        iv_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy", 32'(busy_a), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 32'(ov_a), 32'd0);
        check("arst_data",  32'(od_a), 32'd0);
        check("arst_busy",  32'(busy_a), 32'd0);
        check("arst_carry", 32'(co_a), 32'd0);
        check("arst_ready", 32'(ir_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run(1'b0, 16'h0001, SH_LSL, 4'd1, 16'h0002, 1'b0, 1, 1'b0, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
